// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalisation LUT builder.
package hist_eq_pkg;

  localparam int NUM_BINS     = 256;
  localparam int DRAIN_CYCLES = 3;
  localparam int LUT_MAX      = 255;

  // Build sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Contents are not reset, so the array maps onto block RAM.
module dp_bram #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; the read register carries no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hist_eq_scale.sv
// CDF-to-8-bit scaler: scaled = min((cdf * 255) >> PIX_LOG2, 255), registered.
// Unsigned arithmetic, truncating shift, no rounding.
module hist_eq_scale
  import hist_eq_pkg::*;
#(
  parameter int PIX_LOG2 = 16,
  parameter int CDF_W    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CDF_W-1:0] cdf,
  output logic [7:0]       scaled
);

  logic [CDF_W+7:0] product;
  logic [CDF_W+7:0] shifted;

  assign product = {8'd0, cdf} * (CDF_W+8)'(LUT_MAX);
  assign shifted = product >> PIX_LOG2;

  // Register the saturated result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scaled <= 8'd0;
    end else if (shifted > (CDF_W+8)'(LUT_MAX)) begin
      scaled <= 8'(LUT_MAX);
    end else begin
      scaled <= shifted[7:0];
    end
  end

endmodule

// File: rtl/histogram_eq_lut.sv
// Histogram-equalisation LUT builder and pixel remapper.
// On hist_ready it sweeps the 256 histogram bins, accumulates the CDF,
// scales it to 8 bits and writes the mapping LUT; the live pixel stream is
// remapped through the last completed LUT with a 2-cycle latency.
// Optional build macro HIST_EQ_DOUBLE_BUFFER_EN: two LUT banks, the build
// fills the inactive bank and the banks swap at DONE. Without it a single
// bank is used and pixels pass through unchanged while a build is running.
module histogram_eq_lut
  import hist_eq_pkg::*;
#(
  parameter int PIX_LOG2 = 16,
  parameter int BIN_W    = 16,
  parameter int CDF_W    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hist_ready,
  output logic [7:0]       hist_addr,
  input  logic [BIN_W-1:0] hist_data,
  input  logic [7:0]       in_pixel,
  input  logic             in_valid,
  output logic [7:0]       out_pixel,
  output logic             out_valid,
  output logic             busy,
  output logic             build_done,
  output logic             lut_valid
);

  state_t           state;
  logic [1:0]       drain_cnt;
  logic             pending;

  // Build pipeline: read issue -> data -> cdf -> scaled -> LUT write
  logic             rd_v1, rd_v2, wr_v3;
  logic [7:0]       addr_d1, addr_d2, addr_d3;
  logic [CDF_W-1:0] cdf;
  logic [7:0]       scaled;

  // Apply path
  logic             use_lut;
  logic [7:0]       pix_d;
  logic             valid_d;
  logic             use_lut_d;
  logic [7:0]       lut_q;

`ifdef HIST_EQ_DOUBLE_BUFFER_EN
  localparam int LUT_DEPTH = 2 * NUM_BINS;
  logic       active_bank;
  logic [8:0] lut_waddr;
  logic [8:0] lut_raddr;

  assign lut_waddr = {~active_bank, addr_d3};
  assign lut_raddr = {active_bank, in_pixel};
  assign use_lut   = lut_valid;

  // Swap banks when a build completes; takes effect the following cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_bank <= 1'b0;
    end else if (state == DONE) begin
      active_bank <= ~active_bank;
    end
  end
`else
  localparam int LUT_DEPTH = NUM_BINS;
  logic [7:0] lut_waddr;
  logic [7:0] lut_raddr;

  assign lut_waddr = addr_d3;
  assign lut_raddr = in_pixel;
  // The single bank is being overwritten during a build, so pass pixels through
  assign use_lut   = lut_valid & ~busy;
`endif

  // Build sequencer with registered status outputs and one-deep request queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hist_addr  <= 8'd0;
      drain_cnt  <= 2'd0;
      pending    <= 1'b0;
      busy       <= 1'b0;
      build_done <= 1'b0;
      lut_valid  <= 1'b0;
    end else begin
      build_done <= 1'b0;
      case (state)
        IDLE: begin
          if (hist_ready || pending) begin
            state     <= SWEEP;
            hist_addr <= 8'd0;
            busy      <= 1'b1;
            pending   <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        SWEEP: begin
          if (hist_ready) begin
            pending <= 1'b1;
          end
          if (hist_addr == 8'(NUM_BINS - 1)) begin
            state     <= DRAIN;
            drain_cnt <= 2'd0;
          end else begin
            hist_addr <= hist_addr + 8'd1;
          end
        end
        DRAIN: begin
          if (hist_ready) begin
            pending <= 1'b1;
          end
          if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
            state      <= DONE;
            build_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          lut_valid <= 1'b1;
          // A queued request restarts immediately, so busy does not drop
          busy      <= pending | hist_ready;
          if (hist_ready) begin
            pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track bin index and validity alongside the read data and CDF stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1   <= 1'b0;
      rd_v2   <= 1'b0;
      wr_v3   <= 1'b0;
      addr_d1 <= 8'd0;
      addr_d2 <= 8'd0;
      addr_d3 <= 8'd0;
    end else begin
      rd_v1   <= (state == SWEEP);
      rd_v2   <= rd_v1;
      wr_v3   <= rd_v2;
      addr_d1 <= hist_addr;
      addr_d2 <= addr_d1;
      addr_d3 <= addr_d2;
    end
  end

  // CDF accumulator, cleared while idle so each build starts from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdf <= '0;
    end else if (state == IDLE) begin
      cdf <= '0;
    end else if (rd_v1) begin
      cdf <= cdf + CDF_W'(hist_data);
    end
  end

  hist_eq_scale #(
    .PIX_LOG2 (PIX_LOG2),
    .CDF_W    (CDF_W)
  ) u_scale (
    .clk    (clk),
    .rst    (rst),
    .cdf    (cdf),
    .scaled (scaled)
  );

  dp_bram #(
    .DEPTH  (LUT_DEPTH),
    .WIDTH  (8),
    .ADDR_W ($clog2(LUT_DEPTH))
  ) u_lut (
    .clk   (clk),
    .we    (wr_v3),
    .waddr (lut_waddr),
    .wdata (scaled),
    .raddr (lut_raddr),
    .rdata (lut_q)
  );

  // Apply stage 1: capture pixel and the LUT-select decision with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_d     <= 8'd0;
      valid_d   <= 1'b0;
      use_lut_d <= 1'b0;
    end else begin
      pix_d     <= in_pixel;
      valid_d   <= in_valid;
      use_lut_d <= use_lut;
    end
  end

  // Apply stage 2: choose LUT output or identity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pixel <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid_d;
      out_pixel <= use_lut_d ? lut_q : pix_d;
    end
  end

endmodule

// File: tb/tb_histogram_eq_lut.sv
// Self-checking bench for histogram_eq_lut (PIX_LOG2 = 8).
// Expected pixels are pushed to a scoreboard when driven and compared when
// out_valid appears; build timing is checked at fixed cycle offsets.
module tb_histogram_eq_lut;

  localparam int PIX_LOG2 = 8;
  localparam int BIN_W    = 16;
  localparam int CDF_W    = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             hist_ready = 1'b0;
  logic [7:0]       hist_addr;
  logic [BIN_W-1:0] hist_data = '0;
  logic [7:0]       in_pixel = 8'd0;
  logic             in_valid = 1'b0;
  logic [7:0]       out_pixel;
  logic             out_valid;
  logic             busy;
  logic             build_done;
  logic             lut_valid;

  histogram_eq_lut #(
    .PIX_LOG2 (PIX_LOG2),
    .BIN_W    (BIN_W),
    .CDF_W    (CDF_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hist_ready (hist_ready),
    .hist_addr  (hist_addr),
    .hist_data  (hist_data),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .busy       (busy),
    .build_done (build_done),
    .lut_valid  (lut_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Histogram RAM model with one-cycle read latency
  logic [BIN_W-1:0] hist_mem [256];
  always @(posedge clk) hist_data <= hist_mem[hist_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Build records: sampled cycle and the LUT the bench computed for it
  int         nbld = 0;
  int         bld_t   [8];
  logic [7:0] bld_lut [8][256];

  task automatic add_build(input int t);
    longint c;
    longint v;
    c = 0;
    for (int k = 0; k < 256; k++) begin
      c += hist_mem[k];
      v = (c * 255) >> PIX_LOG2;
      if (v > 255) v = 255;
      bld_lut[nbld][k] = 8'(v);
    end
    bld_t[nbld] = t;
    nbld++;
    $display("build requested at cycle %0d (record %0d)", t, nbld - 1);
  endtask

  function automatic int exp_map(input int pix, input int c);
    int res;
    res = pix;
    for (int i = 0; i < nbld; i++) begin
      if (c >= bld_t[i] + 261) res = bld_lut[i][pix];
    end
`ifndef HIST_EQ_DOUBLE_BUFFER_EN
    for (int i = 0; i < nbld; i++) begin
      if (c >= bld_t[i] + 1 && c <= bld_t[i] + 260) res = pix;
    end
`endif
    return res;
  endfunction

  typedef struct {
    int cyc;
    int pix;
  } sb_t;
  sb_t sb [$];
  int  done_q [$];

  // Output side: pop and compare, and log build_done pulses
  always @(negedge clk) begin
    sb_t e;
    if (build_done) done_q.push_back(cyc);
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("sb_empty", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("latency", cyc, e.cyc + 2);
        check("pixel", out_pixel, e.pix);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int pix, input bit v);
    sb_t e;
    in_pixel = 8'(pix);
    in_valid = v;
    if (v) begin
      e.cyc = cyc;
      e.pix = exp_map(pix, cyc);
      sb.push_back(e);
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0);
  endtask

  task automatic start_build(output int t);
    hist_ready = 1'b1;
    t = cyc;
    add_build(t);
    drive(0, 1'b0);
    hist_ready = 1'b0;
  endtask

  task automatic goto_cycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic stream_all();
    for (int p = 0; p < 256; p++) drive(p, 1'b1);
    idle(4);
  endtask

  task automatic set_hist(input int bin, input int val, input int rest);
    for (int k = 0; k < 256; k++) hist_mem[k] = 16'(rest);
    if (bin >= 0) hist_mem[bin] = 16'(val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    set_hist(-1, 0, 0);

    // Reset values
    goto_cycle(2);
    check("rst_hist_addr", hist_addr, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_build_done", build_done, 0);
    check("rst_lut_valid", lut_valid, 0);
    step();
    rst = 1'b1;
    idle(2);

    // Identity with no LUT, irregular valid pattern
    for (int p = 0; p < 256; p++) drive(p, ($urandom_range(0, 3) != 0));
    idle(4);
    check("id_lut_valid", lut_valid, 0);

    // Uniform histogram: exact build timing and linear mapping
    set_hist(-1, 0, 1);
    done_q.delete();
    start_build(t);
    goto_cycle(t + 1);
    check("b1_addr_first", hist_addr, 0);
    check("b1_busy_first", busy, 1);
    goto_cycle(t + 256);
    check("b1_addr_last", hist_addr, 255);
    goto_cycle(t + 260);
    check("b1_done", build_done, 1);
    check("b1_busy_done", busy, 1);
    check("b1_lutv_before", lut_valid, 0);
    goto_cycle(t + 261);
    check("b1_done_clr", build_done, 0);
    check("b1_busy_clr", busy, 0);
    check("b1_lutv_after", lut_valid, 1);
    step();
    stream_all();
    check("b1_done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("b1_done_cycle", done_q[0], t + 260);

    // Step at bin 100
    set_hist(100, 256, 0);
    start_build(t);
    goto_cycle(t + 262);
    step();
    stream_all();

    // Saturation: 512 * 255 >> 8 = 510 clips to 255
    set_hist(0, 512, 0);
    start_build(t);
    goto_cycle(t + 262);
    step();
    stream_all();

    // Continuous pixel 100 across a rebuild: old LUT gives 37, new gives 200
    set_hist(0, 38, 0);
    start_build(t);
    goto_cycle(t + 262);
    step();
    set_hist(0, 201, 0);
    for (int i = 0; i < 290; i++) begin
      if (i == 10) begin
        hist_ready = 1'b1;
        add_build(cyc);
      end
      drive(100, 1'b1);
      hist_ready = 1'b0;
    end
    idle(4);

    // Requests during a build: exactly one extra build, busy continuous
    set_hist(-1, 0, 1);
    done_q.delete();
    start_build(t);
    while (cyc < t + 50) drive(0, 1'b0);
    hist_ready = 1'b1;
    drive(0, 1'b0);
    hist_ready = 1'b0;
    while (cyc < t + 80) drive(0, 1'b0);
    hist_ready = 1'b1;
    drive(0, 1'b0);
    hist_ready = 1'b0;
    add_build(t + 261);
    goto_cycle(t + 260);
    check("pend_busy_done", busy, 1);
    goto_cycle(t + 261);
    check("pend_busy_gap", busy, 1);
    goto_cycle(t + 262);
    check("pend_busy_restart", busy, 1);
    check("pend_addr_restart", hist_addr, 0);
    goto_cycle(t + 522);
    check("pend_busy_end", busy, 0);
    goto_cycle(t + 800);
    check("pend_done_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("pend_done_1", done_q[0], t + 260);
      check("pend_done_2", done_q[1], t + 521);
    end
    step();
    stream_all();

    // Reset in the middle of a build
    set_hist(100, 256, 0);
    start_build(t);
    while (cyc < t + 120) drive(0, 1'b0);
    done_q.delete();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_lut_valid", lut_valid, 0);
    check("mid_rst_hist_addr", hist_addr, 0);
    check("mid_rst_out_valid", out_valid, 0);
    nbld = 0;
    step();
    step();
    rst = 1'b1;
    step();
    stream_all();
    idle(300);
    check("mid_rst_no_done", done_q.size(), 0);
    check("mid_rst_busy_idle", busy, 0);

    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
